// File: rtl/stream_width_upsizer.sv
`default_nettype none
// ============================================================================
//  Module      : stream_width_upsizer
//  Description : Packs a narrow valid/ready beat stream into wide words,
//                little-endian by lane, with a per-lane keep mask and a
//                packet-end flag. A beat carrying i_last closes the word
//                early (partial word, unfilled lanes zero). Sustains one
//                input beat per cycle while downstream is ready.
//  Ports       : clk, reset    - clock, synchronous active-high reset
//                i_valid/i_data/i_last/i_ready - upstream beat handshake
//                o_valid/o_data/o_keep/o_last/o_ready - downstream word
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_width_upsizer #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_valid,
    input  logic [IN_WIDTH-1:0]                i_data,
    input  logic                               i_last,
    output logic                               i_ready,
    output logic                               o_valid,
    output logic [OUT_WIDTH-1:0]               o_data,
    output logic [OUT_WIDTH/IN_WIDTH-1:0]      o_keep,
    output logic                               o_last,
    input  logic                               o_ready
);

    localparam int RATIO = OUT_WIDTH / IN_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] c_last_lane = CNT_W'(RATIO - 1);

    // Packing state for the word under construction
    logic [CNT_W-1:0]     r_cnt;
    logic [OUT_WIDTH-1:0] r_pack;
    logic [RATIO-1:0]     r_pkeep;

    // Registered output word
    logic                 r_valid;
    logic [OUT_WIDTH-1:0] r_data;
    logic [RATIO-1:0]     r_keep;
    logic                 r_last;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_complete;
    logic [OUT_WIDTH-1:0] w_merged_data;
    logic [RATIO-1:0]     w_merged_keep;

    // Ready only depends on the output register being free or draining,
    // so a completing beat can replace a word leaving on the same edge.
    assign w_ready    = !r_valid || o_ready;
    assign w_accept   = i_valid && w_ready;
    assign w_complete = (r_cnt == c_last_lane) || i_last;

    // Pack register with the incoming beat dropped into the current lane
    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        assign w_merged_data[g*IN_WIDTH +: IN_WIDTH] =
            (r_cnt == CNT_W'(g)) ? i_data : r_pack[g*IN_WIDTH +: IN_WIDTH];
        assign w_merged_keep[g] = (r_cnt == CNT_W'(g)) || r_pkeep[g];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_pack  <= '0;
            r_pkeep <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else begin
            // Drain first; a completion on the same edge overrides it below
            if (r_valid && o_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_complete) begin
                    r_valid <= 1'b1;
                    r_data  <= w_merged_data;
                    r_keep  <= w_merged_keep;
                    r_last  <= i_last;
                    r_cnt   <= '0;
                    r_pack  <= '0;
                    r_pkeep <= '0;
                end else begin
                    r_pack  <= w_merged_data;
                    r_pkeep <= w_merged_keep;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign i_ready = w_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_stream_width_upsizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_width_upsizer
//  Description : Self-checking bench for stream_width_upsizer: a directed
//                per-cycle vector table followed by randomized traffic,
//                with a packet-level reference model checking every
//                delivered word, ready behaviour and output stability.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_width_upsizer;

    localparam int IN_WIDTH  = 8;
    localparam int OUT_WIDTH = 32;
    localparam int RATIO     = OUT_WIDTH / IN_WIDTH;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 i_valid;
    logic [IN_WIDTH-1:0]  i_data;
    logic                 i_last;
    logic                 i_ready;
    logic                 o_valid;
    logic [OUT_WIDTH-1:0] o_data;
    logic [RATIO-1:0]     o_keep;
    logic                 o_last;
    logic                 o_ready;

    int n_vec = 0;
    int n_err = 0;

    stream_width_upsizer #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_last  (i_last),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_keep  (o_keep),
        .o_last  (o_last),
        .o_ready (o_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: collects accepted beats per packet and emits the
    // expected word whenever four beats are gathered or a last beat arrives.
    // Observed at the falling edge, i.e. predicting the next rising edge.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] part[$];
    logic       prev_stall = 1'b0;
    word_t      prev_word;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("i_ready_rule", i_ready, (!o_valid || o_ready));
            if (prev_stall) begin
                chk("stall_valid", o_valid, 1'b1);
                chk("stall_word", {o_data, o_keep, o_last}, prev_word);
            end
            if (reset) begin
                exp_q.delete();
                part.delete();
                prev_stall = 1'b0;
            end else begin
                if (o_valid && o_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_word", 1'b1, 1'b0);
                    end else begin
                        word_t w;
                        w = exp_q.pop_front();
                        chk("word", {o_data, o_keep, o_last}, w);
                    end
                end
                if (i_valid && i_ready) begin
                    part.push_back(i_data);
                    if (part.size() == RATIO || i_last) begin
                        word_t w;
                        w.data = '0;
                        foreach (part[k]) w.data = w.data | (32'(part[k]) << (8 * k));
                        w.keep = 4'((1 << part.size()) - 1);
                        w.last = i_last;
                        exp_q.push_back(w);
                        part.delete();
                    end
                end
                prev_stall = o_valid && !o_ready;
                prev_word  = {o_data, o_keep, o_last};
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed per-cycle vectors: inputs held for one cycle, i_ready
    // checked before the edge, outputs checked just after it.
    // ------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        ordy;
        logic        e_irdy;
        logic        e_ov;
        logic [31:0] e_od;
        logic [3:0]  e_ok;
        logic        e_ol;
        logic        cd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic v, input logic [7:0] d,
                                input logic l, input logic ordy, input logic e_irdy,
                                input logic e_ov, input logic [31:0] e_od,
                                input logic [3:0] e_ok, input logic e_ol, input logic cd);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.l = l; r.ordy = ordy; r.e_irdy = e_irdy;
        r.e_ov = e_ov; r.e_od = e_od; r.e_ok = e_ok; r.e_ol = e_ol; r.cd = cd;
        return r;
    endfunction

    task automatic idle_row();
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0));
    endtask

    initial begin
        logic stall;

        reset = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0; o_ready = 1'b1;

        // Reset state
        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0, 1));
        // Full word with last on lane 3
        tbl.push_back(mk(0, 1, 8'hEF, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hBE, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hAD, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hDE, 1, 1, 1, 1, 32'hDEADBEEF, 4'hF, 1, 1));
        // Partial packets, then single-lane packet back to back
        tbl.push_back(mk(0, 1, 8'h11, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h22, 1, 1, 1, 1, 32'h00002211, 4'h3, 1, 1));
        tbl.push_back(mk(0, 1, 8'h33, 1, 1, 1, 1, 32'h00000033, 4'h1, 1, 1));
        idle_row();
        // Back-pressure: counter-completed word held for 10 cycles
        tbl.push_back(mk(0, 1, 8'h78, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h56, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h34, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h12, 0, 0, 1, 1, 32'h12345678, 4'hF, 0, 1));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 1, 8'h99, 1, 0, 0, 1, 32'h12345678, 4'hF, 0, 1));
        // Release: drain and accept a single-lane last beat on the same edge
        tbl.push_back(mk(0, 1, 8'h99, 1, 1, 1, 1, 32'h00000099, 4'h1, 1, 1));
        idle_row();
        // Throughput: 16 back-to-back bytes
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(0, 1, 8'(i), (i == 15), 1, 1, (i % 4 == 3),
                             {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)}, 4'hF,
                             (i == 15), (i % 4 == 3)));
        idle_row();
        // Reset mid-packet, with a beat presented during reset
        tbl.push_back(mk(0, 1, 8'hAA, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hBB, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0));
        tbl.push_back(mk(1, 1, 8'hCC, 1, 1, 1, 0, 32'h0, 4'h0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h01, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h02, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h03, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h04, 1, 1, 1, 1, 32'h04030201, 4'hF, 1, 1));
        // Edge data patterns
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, 8'h00, (i == 3), 1, 1, (i == 3), 32'h0, 4'hF, 1, (i == 3)));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, 8'hFF, (i == 3), 1, 1, (i == 3), 32'hFFFFFFFF, 4'hF, 1, (i == 3)));
        idle_row();

        foreach (tbl[n]) begin
            reset   = tbl[n].rst;
            i_valid = tbl[n].v;
            i_data  = tbl[n].d;
            i_last  = tbl[n].l;
            o_ready = tbl[n].ordy;
            @(negedge clk);
            if (!tbl[n].rst) chk($sformatf("v%0d_i_ready", n), i_ready, tbl[n].e_irdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_o_valid", n), o_valid, tbl[n].e_ov);
            if (tbl[n].cd) begin
                chk($sformatf("v%0d_o_data", n), o_data, tbl[n].e_od);
                chk($sformatf("v%0d_o_keep", n), o_keep, tbl[n].e_ok);
                chk($sformatf("v%0d_o_last", n), o_last, tbl[n].e_ol);
            end
        end

        // Randomized traffic, honouring hold-while-stalled on the input side
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            stall = i_valid && !i_ready;
            if (!stall) begin
                i_valid = ($urandom_range(0, 3) != 0);
                i_data  = 8'($urandom_range(0, 255));
                i_last  = ($urandom_range(0, 4) == 0);
            end
            o_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end

        // Drain whatever is still pending
        i_valid = 1'b0;
        o_ready = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_width_upsizer.md
Name: stream_width_upsizer

Overview:
Packs a narrow valid/ready byte stream into wide words for the 32-bit datapath stage directly downstream. Each output word carries a per-lane keep mask and a packet-end flag. A packet end forces an early, partial word. Sustains one input beat per cycle when downstream is ready.

Parameters:
IN_WIDTH, 8, input beat width in bits
OUT_WIDTH, 32, output word width in bits; OUT_WIDTH/IN_WIDTH = RATIO, integer power of 2, >= 2
RATIO, OUT_WIDTH/IN_WIDTH, lanes per word (localparam, not overridable)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
i_valid  input  1  upstream beat valid
i_data  input  IN_WIDTH  upstream beat
i_last  input  1  beat is last of packet
i_ready  output  1  block accepts beat this cycle
o_valid  output  1  output word valid
o_data  output  OUT_WIDTH  packed word
o_keep  output  RATIO  lane k valid when bit k = 1
o_last  output  1  word ends a packet
o_ready  input  1  downstream accepts word

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: o_valid=0, o_data=0, o_keep=0, o_last=0. Internal state after reset: lane counter=0, pack register=0, pack keep=0.
- Handshake: a transfer occurs on a rising edge with valid && ready high.
- Upstream must hold i_data and i_last stable while i_valid && !i_ready. Downstream may rely on the same from this block.
- i_ready = !o_valid || o_ready. This is combinational from o_ready; there is no other dependency.
- Lane order is little-endian. The beat accepted at lane counter k goes to bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH], and keep bit k is set.
- Completion beat: an accepted beat with lane counter == RATIO-1, or with i_last=1.
- Non-completion beat accepted: write the lane, increment the lane counter, output register unchanged.
- Completion beat accepted, on the same edge:
  - o_data = pack register with the current lane merged in; unfilled lanes are 0.
  - o_keep = accumulated keep with the current bit set.
  - o_last = i_last.
  - o_valid = 1.
  - Lane counter, pack register and pack keep are cleared to 0.
- Latency: o_valid rises on the edge that accepts the completion beat, so the word is visible the cycle after the last beat is presented.
- Output drain: o_valid && o_ready with no new completion beat on that edge -> o_valid=0 next cycle. o_data, o_keep and o_last may hold their stale values.
- Simultaneous drain and completion: both happen on the same edge and o_valid stays 1 with the new word. Full throughput needs no bubble.
- Back-pressure: while o_valid && !o_ready, i_ready=0. No beat is accepted and all state holds. Output fields must not change while o_valid && !o_ready.
- i_last on lane 0 gives a single-lane word: o_keep = 4'b0001 at the default RATIO, o_last=1.
- i_last on lane RATIO-1 gives a full word with o_last=1.
- Keep is always contiguous from bit 0; a gapped keep mask is never produced.
- Idle: with i_valid=0, no state changes except the output drain.
- Reset mid-packet: a partial packet and any pending output word are discarded. Outputs return to reset values the cycle after reset is sampled high. i_ready=1 during and after reset, but beats presented while reset=1 are ignored.
- The lane counter is $clog2(RATIO) bits and wraps naturally from RATIO-1 to 0.

Test Plan:
1. Full word, o_ready=1: bytes 0xEF,0xBE,0xAD,0xDE, last on 4th -> one word 0xDEADBEEF, keep 4'hF, o_last=1, o_valid the cycle after the 4th beat.
2. Partial packet: 0x11,0x22 with i_last on 2nd -> o_data 0x00002211, keep 4'h3, o_last=1.
   Then 0x33 with i_last -> 0x00000033, keep 4'h1. Check that counter restart leaves no residue.
3. Back-pressure: o_ready=0 for 10 cycles after the word 0x12345678 (bytes 78,56,34,12) completes.
   -> i_ready=0 and the word is stable for 10 cycles.
   Raise o_ready -> single transfer, i_ready=1 the same cycle.
4. Throughput: 16 back-to-back bytes 0x00..0x0F, o_ready=1, one i_last at the end.
   -> 4 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive completion cycles.
   i_ready never deasserts; o_last only on the 4th word.
5. Reset mid-packet: accept 0xAA,0xBB, pulse reset 1 cycle, then send 0x01..0x04 with last.
   -> only the word 0x04030201, keep 4'hF; all outputs 0 during reset.
6. Edge patterns: bytes 0x00×4 -> 0x00000000, then 0xFF×4 -> 0xFFFFFFFF, each with keep 4'hF.
   Random o_ready toggling -> no word lost or duplicated (scoreboard).
